// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - two-requester writeback arbiter with register-file write port and pending-write scoreboard
//
// Purpose:
//   Arbitrates two writeback requesters onto one register-file write port
//   (round robin on contention), registers that write port, and keeps a
//   per-register count of issued-but-not-yet-written results so the decode
//   stage can stall on RAW/WAW hazards.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   req0_valid/addr/data/pc       requester 0 (load/ALU pipeline)
//   req0_ready                    requester 0 granted this cycle
//   req1_valid/addr/data/pc       requester 1 (mult/div unit)
//   req1_ready                    requester 1 granted this cycle
//   mark_valid, mark_addr         an issued instruction will later write mark_addr
//   rs_addr, rt_addr              source registers of the decoding instruction
//   rs_use, rt_use                source actually read
//   stall                         decoding instruction must hold
//   rf_we, rf_a3, rf_wd, rf_pc    registered register-file write port
//   err                           sticky pending-counter overflow/underflow

module wb_arbiter #(
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [4:0]  req0_addr,
  input  logic [31:0] req0_data,
  input  logic [31:0] req0_pc,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_addr,
  input  logic [31:0] req1_data,
  input  logic [31:0] req1_pc,
  output logic        req1_ready,
  input  logic        mark_valid,
  input  logic [4:0]  mark_addr,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  input  logic        rs_use,
  input  logic        rt_use,
  output logic        stall,
  output logic        rf_we,
  output logic [4:0]  rf_a3,
  output logic [31:0] rf_wd,
  output logic [31:0] rf_pc,
  output logic        err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             grant0, grant1;
  logic             last_grant_q, last_grant_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_a3_q, rf_a3_d;
  logic [31:0]      rf_wd_q, rf_wd_d;
  logic [31:0]      rf_pc_q, rf_pc_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q [1:31];
  logic [CNT_W-1:0] cnt_d [1:31];
  logic [31:0]      inc_vec, dec_vec, busy_vec;

  // On contention the requester not granted last time wins.
  always_comb begin
    grant0 = req0_valid & (~req1_valid | last_grant_q);
    grant1 = req1_valid & (~req0_valid | ~last_grant_q);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    last_grant_d = last_grant_q;
    rf_we_d      = 1'b0;
    rf_a3_d      = rf_a3_q;
    rf_wd_d      = rf_wd_q;
    rf_pc_d      = rf_pc_q;
    if (grant0) begin
      last_grant_d = 1'b0;
      rf_we_d      = |req0_addr;
      rf_a3_d      = req0_addr;
      rf_wd_d      = req0_data;
      rf_pc_d      = req0_pc;
    end else if (grant1) begin
      last_grant_d = 1'b1;
      rf_we_d      = |req1_addr;
      rf_a3_d      = req1_addr;
      rf_wd_d      = req1_data;
      rf_pc_d      = req1_pc;
    end
  end

  // Decrement happens on the edge that actually writes the register file,
  // so a register only reads not-busy once the new value is in place.
  always_comb begin
    inc_vec = mark_valid ? (32'd1 << mark_addr) : 32'd0;
    dec_vec = rf_we_q ? (32'd1 << rf_a3_q) : 32'd0;
    err_d   = err_q;
    for (int r = 1; r < 32; r++) begin
      cnt_d[r] = cnt_q[r];
      if (inc_vec[r] && !dec_vec[r]) begin
        if (cnt_q[r] == CNT_MAX) err_d = 1'b1;
        else                     cnt_d[r] = cnt_q[r] + 1'b1;
      end else if (dec_vec[r] && !inc_vec[r]) begin
        if (cnt_q[r] == '0) err_d = 1'b1;
        else                cnt_d[r] = cnt_q[r] - 1'b1;
      end
    end
  end

  always_comb begin
    busy_vec[0] = 1'b0;
    for (int r = 1; r < 32; r++) busy_vec[r] = |cnt_q[r];
    stall = (rs_use & busy_vec[rs_addr]) | (rt_use & busy_vec[rt_addr]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      rf_we_q      <= 1'b0;
      rf_a3_q      <= '0;
      rf_wd_q      <= '0;
      rf_pc_q      <= '0;
      err_q        <= 1'b0;
      for (int r = 1; r < 32; r++) cnt_q[r] <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rf_we_q      <= rf_we_d;
      rf_a3_q      <= rf_a3_d;
      rf_wd_q      <= rf_wd_d;
      rf_pc_q      <= rf_pc_d;
      err_q        <= err_d;
      for (int r = 1; r < 32; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  assign rf_we = rf_we_q;
  assign rf_a3 = rf_a3_q;
  assign rf_wd = rf_wd_q;
  assign rf_pc = rf_pc_q;
  assign err   = err_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter

module tb_wb_arbiter;

  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 0, req1_valid = 0;
  logic [4:0]  req0_addr = 0, req1_addr = 0;
  logic [31:0] req0_data = 0, req1_data = 0, req0_pc = 0, req1_pc = 0;
  logic        req0_ready, req1_ready;
  logic        mark_valid = 0;
  logic [4:0]  mark_addr = 0, rs_addr = 0, rt_addr = 0;
  logic        rs_use = 0, rt_use = 0;
  logic        stall, rf_we, err;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd, rf_pc;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          m_cnt [32];
  bit          m_err;
  int          m_last;
  bit          m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_wd, m_pc;

  always #5 clk = ~clk;

  wb_arbiter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
    .req0_pc(req0_pc), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
    .req1_pc(req1_pc), .req1_ready(req1_ready),
    .mark_valid(mark_valid), .mark_addr(mark_addr),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_use(rs_use), .rt_use(rt_use),
    .stall(stall), .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd), .rf_pc(rf_pc),
    .err(err)
  );

  function automatic int model_grant();
    if (req0_valid && req1_valid) return (m_last == 0) ? 1 : 0;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  function automatic bit model_stall();
    return (rs_use && m_cnt[rs_addr] != 0) || (rt_use && m_cnt[rt_addr] != 0);
  endfunction

  // Advance the model by one clock edge from the current inputs, then move
  // the bench to 1ns after that edge.
  task automatic cyc();
    int g;
    g = model_grant();
    if (reset) begin
      foreach (m_cnt[r]) m_cnt[r] = 0;
      m_err = 0; m_last = 1; m_we = 0; m_a3 = 0; m_wd = 0; m_pc = 0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        bit inc, dec;
        inc = mark_valid && (mark_addr == r);
        dec = m_we && (m_a3 == r);
        if (inc && !dec) begin
          if (m_cnt[r] == CMAX) m_err = 1; else m_cnt[r]++;
        end else if (dec && !inc) begin
          if (m_cnt[r] == 0) m_err = 1; else m_cnt[r]--;
        end
      end
      if (g == 0) begin
        m_we = (req0_addr != 0); m_a3 = req0_addr; m_wd = req0_data; m_pc = req0_pc; m_last = 0;
      end else if (g == 1) begin
        m_we = (req1_addr != 0); m_a3 = req1_addr; m_wd = req1_data; m_pc = req1_pc; m_last = 1;
      end else begin
        m_we = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; mark_valid = 0; rs_use = 0; rt_use = 0;
    req0_addr = 0; req1_addr = 0; mark_addr = 0; rs_addr = 0; rt_addr = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    cyc();
    reset = 0;
  endtask

  task automatic mark(input logic [4:0] a);
    mark_valid = 1; mark_addr = a;
    cyc();
    mark_valid = 0;
  endtask

  task automatic test_reset();
    reset = 1; req0_valid = 1; req0_addr = 3;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_comb got=%b exp=1", req0_ready); end
    cyc();
    reset = 0;
    idle_inputs();
    #1;
    checks++;
    if (rf_we !== 1'b0 || err !== 1'b0 || rf_a3 !== 5'd0 || rf_wd !== 32'd0 || rf_pc !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs got we=%b err=%b a3=%0d wd=%h pc=%h exp all zero", rf_we, err, rf_a3, rf_wd, rf_pc);
    end
    rs_use = 1;
    for (int r = 0; r < 32; r++) begin
      rs_addr = 5'(r);
      #1;
      checks++;
      if (stall !== 1'b0) begin errors++; $display("FAIL reset_busy r=%0d got stall=%b exp=0", r, stall); end
    end
    rs_use = 0;
  endtask

  task automatic test_contention();
    int exp_a3 [4] = '{5, 6, 5, 6};
    do_reset();
    mark(5); mark(5); mark(6); mark(6);
    req0_valid = 1; req0_addr = 5; req0_data = 32'hA0A0_0000; req0_pc = 32'h100;
    req1_valid = 1; req1_addr = 6; req1_data = 32'hB1B1_0000; req1_pc = 32'h200;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (req0_ready !== ((i % 2) == 0) || req1_ready !== ((i % 2) == 1)) begin
        errors++;
        $display("FAIL contention_grant i=%0d got r0=%b r1=%b exp grant%0d", i, req0_ready, req1_ready, i % 2);
      end
      cyc();
      checks++;
      if (rf_we !== 1'b1 || rf_a3 !== 5'(exp_a3[i]) || rf_wd !== ((i % 2) ? 32'hB1B1_0000 : 32'hA0A0_0000)) begin
        errors++;
        $display("FAIL contention_write i=%0d got we=%b a3=%0d wd=%h exp a3=%0d", i, rf_we, rf_a3, rf_wd, exp_a3[i]);
      end
    end
    idle_inputs();
    cyc();
    rs_use = 1; rs_addr = 5; rt_use = 1; rt_addr = 6;
    #1;
    checks++;
    if (err !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL contention_drain got err=%b stall=%b exp 0/0", err, stall);
    end
  endtask

  task automatic test_scoreboard();
    do_reset();
    mark(8);
    rs_addr = 8; rs_use = 1;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL sb_stall_after_mark got=%b exp=1", stall); end
    req1_valid = 1; req1_addr = 8; req1_data = 32'h1234; req1_pc = 32'h40;
    #1;
    checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      errors++; $display("FAIL sb_ready got r1=%b r0=%b exp 1/0", req1_ready, req0_ready);
    end
    cyc();
    req1_valid = 0;
    #1;
    checks++;
    if (rf_we !== 1'b1 || rf_a3 !== 5'd8 || rf_wd !== 32'h1234 || rf_pc !== 32'h40 || stall !== 1'b1) begin
      errors++;
      $display("FAIL sb_write got we=%b a3=%0d wd=%h pc=%h stall=%b exp 1/8/1234/40/1", rf_we, rf_a3, rf_wd, rf_pc, stall);
    end
    cyc();
    checks++;
    if (stall !== 1'b0 || rf_we !== 1'b0) begin
      errors++; $display("FAIL sb_release got stall=%b we=%b exp 0/0", stall, rf_we);
    end
  endtask

  task automatic test_waw();
    do_reset();
    mark(9); mark(9);
    rs_addr = 9; rs_use = 1;
    for (int k = 0; k < 2; k++) begin
      req0_valid = 1; req0_addr = 9; req0_data = 32'(k);
      cyc();
      req0_valid = 0;
      cyc();
      checks++;
      if (stall !== (k == 0) || err !== 1'b0) begin
        errors++; $display("FAIL waw k=%0d got stall=%b err=%b exp stall=%0d err=0", k, stall, err, k == 0);
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    mark(10);
    req0_valid = 1; req0_addr = 10;
    cyc();
    req0_valid = 0; mark_valid = 1; mark_addr = 10;
    cyc();
    mark_valid = 0; rs_addr = 10; rs_use = 1;
    #1;
    checks++;
    if (stall !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL simul_same_reg got stall=%b err=%b exp 1/0", stall, err);
    end
    mark_valid = 1; mark_addr = 0;
    cyc();
    mark_valid = 0; rs_addr = 0; rt_addr = 0; rt_use = 1;
    #1;
    checks++;
    if (stall !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL simul_reg0 got stall=%b err=%b exp 0/0", stall, err);
    end
    req1_valid = 1; req1_addr = 0;
    cyc();
    req1_valid = 0;
    checks++;
    if (rf_we !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL simul_addr0_write got we=%b err=%b exp 0/0", rf_we, err);
    end
  endtask

  task automatic test_errors();
    do_reset();
    req1_valid = 1; req1_addr = 11;
    cyc();
    req1_valid = 0;
    cyc();
    rs_addr = 11; rs_use = 1;
    #1;
    checks++;
    if (err !== 1'b1 || stall !== 1'b0) begin
      errors++; $display("FAIL err_underflow got err=%b stall=%b exp 1/0", err, stall);
    end
    do_reset();
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_reset_clear got=%b exp=0", err); end
    for (int k = 0; k < 4; k++) mark(12);
    rs_addr = 12; rs_use = 1;
    #1;
    checks++;
    if (err !== 1'b1 || stall !== 1'b1) begin
      errors++; $display("FAIL err_overflow got err=%b stall=%b exp 1/1", err, stall);
    end
    for (int k = 0; k < CMAX; k++) begin
      req0_valid = 1; req0_addr = 12;
      cyc();
      req0_valid = 0;
      cyc();
      checks++;
      if (stall !== (k < CMAX - 1)) begin
        errors++; $display("FAIL err_saturated_count k=%0d got stall=%b exp=%0d", k, stall, k < CMAX - 1);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    mark(13); mark(15);
    req0_valid = 1; req0_addr = 13; req0_data = 32'hD13;
    cyc();
    req0_valid = 0;
    checks++;
    if (rf_we !== 1'b1 || rf_a3 !== 5'd13) begin
      errors++; $display("FAIL midrst_grant got we=%b a3=%0d exp 1/13", rf_we, rf_a3);
    end
    reset = 1; req1_valid = 1; req1_addr = 14;
    #1;
    checks++;
    if (req1_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready_comb got=%b exp=1", req1_ready); end
    cyc();
    reset = 0; req1_valid = 0;
    rs_use = 1; rs_addr = 13; rt_use = 1; rt_addr = 15;
    #1;
    checks++;
    if (rf_we !== 1'b0 || err !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL midrst_state got we=%b err=%b stall=%b exp 0/0/0", rf_we, err, stall);
    end
    req0_valid = 1; req0_addr = 3; req1_valid = 1; req1_addr = 4;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL midrst_first_contention got r0=%b r1=%b exp 1/0", req0_ready, req1_ready);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    int g_prev;
    g_prev = -1;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      // an ungranted request must stay stable until it is granted
      if (!(req0_valid && g_prev != 0)) begin
        req0_valid = $urandom_range(0, 1); req0_addr = 5'($urandom_range(0, 7));
        req0_data = $urandom(); req0_pc = $urandom();
      end
      if (!(req1_valid && g_prev != 1)) begin
        req1_valid = $urandom_range(0, 1); req1_addr = 5'($urandom_range(0, 7));
        req1_data = $urandom(); req1_pc = $urandom();
      end
      mark_valid = $urandom_range(0, 1); mark_addr = 5'($urandom_range(0, 7));
      rs_use = $urandom_range(0, 1); rs_addr = 5'($urandom_range(0, 7));
      rt_use = $urandom_range(0, 1); rt_addr = 5'($urandom_range(0, 7));
      #1;
      g_prev = model_grant();
      checks++;
      if (req0_ready !== (g_prev == 0) || req1_ready !== (g_prev == 1) || stall !== model_stall()) begin
        errors++;
        $display("FAIL rand_comb n=%0d got r0=%b r1=%b stall=%b exp grant=%0d stall=%0d",
                 n, req0_ready, req1_ready, stall, g_prev, model_stall());
      end
      cyc();
      checks++;
      if (rf_we !== m_we || err !== m_err || (m_we && (rf_a3 !== m_a3 || rf_wd !== m_wd || rf_pc !== m_pc))) begin
        errors++;
        $display("FAIL rand_seq n=%0d got we=%b a3=%0d wd=%h err=%b exp we=%0d a3=%0d wd=%h err=%0d",
                 n, rf_we, rf_a3, rf_wd, err, m_we, m_a3, m_wd, m_err);
      end
    end
    reset = 0;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_contention();
    test_scoreboard();
    test_waw();
    test_simultaneous();
    test_errors();
    test_reset_mid_write();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
